// File: rtl/spi_frame_fsm_pkg.sv
//------------------------------------------------------------------------------
// Module      : spi_frame_fsm_pkg
// Description : Shared state encodings and sizing helpers for the SPI frame FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package spi_frame_fsm_pkg;

    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_GET_HDR      = 3'd1;
    localparam logic [2:0] c_DECODE       = 3'd2;
    localparam logic [2:0] c_WRITE_DATA   = 3'd3;
    localparam logic [2:0] c_WRITE_COMMIT = 3'd4;
    localparam logic [2:0] c_READ_LOAD    = 3'd5;
    localparam logic [2:0] c_READ_SHIFT   = 3'd6;
    localparam logic [2:0] c_DONE         = 3'd7;

    // Read/write flag is the last header bit shifted in, so it lands at bit 0.
    localparam int c_RW_BIT = 0;

    function automatic int hdr_bits(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int max_bits(input int addr_width, input int data_width);
        return (hdr_bits(addr_width) > data_width) ? hdr_bits(addr_width) : data_width;
    endfunction

    function automatic int cnt_width(input int addr_width, input int data_width);
        return $clog2(max_bits(addr_width, data_width) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_frame_fsm_if.sv
//------------------------------------------------------------------------------
// Module      : spi_frame_fsm_if
// Description : Conditioned SPI inputs, memory port and MISO outputs bundle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface spi_frame_fsm_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  cs_cond;
    logic                  mosi_cond;
    logic                  sclk_pos;
    logic                  sclk_neg;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  miso;
    logic                  miso_oe;
    logic                  busy;

    modport slave (
        input  cs_cond, mosi_cond, sclk_pos, sclk_neg, mem_rdata,
        output mem_addr, mem_we, mem_wdata, miso, miso_oe, busy
    );

    modport master (
        output cs_cond, mosi_cond, sclk_pos, sclk_neg, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, miso, miso_oe, busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_frame_fsm_shift_register.sv
//------------------------------------------------------------------------------
// Module      : shift_register
// Description : MSB-first shifter with clear, parallel load and serial/parallel out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module shift_register #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_clr,
    input  wire logic             i_load_en,
    input  wire logic [WIDTH-1:0] i_load_data,
    input  wire logic             i_shift_en,
    input  wire logic             i_serial_in,
    output logic                  o_serial_out,
    output logic      [WIDTH-1:0] o_par_out
);
    logic [WIDTH-1:0] r_q;

    // Clear beats load beats shift when more than one is requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load_en) begin
            r_q <= i_load_data;
        end else if (i_shift_en) begin
            r_q <= {r_q[WIDTH-2:0], i_serial_in};
        end
    end

    assign o_serial_out = r_q[WIDTH-1];
    assign o_par_out    = r_q;
endmodule

`default_nettype wire

// File: rtl/spi_frame_fsm.sv
//------------------------------------------------------------------------------
// Module      : spi_frame_fsm
// Description : SPI slave frame engine: header decode, memory write or MISO read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_frame_fsm #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    spi_frame_fsm_if.slave bus
);
    import spi_frame_fsm_pkg::*;

    localparam int c_HDR_BITS = hdr_bits(ADDR_WIDTH);
    localparam int c_IN_W     = max_bits(ADDR_WIDTH, DATA_WIDTH);
    localparam int c_CNT_W    = cnt_width(ADDR_WIDTH, DATA_WIDTH);

    localparam logic [c_CNT_W-1:0] c_HDR_LAST  = c_CNT_W'(c_HDR_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_CNT  = c_CNT_W'(DATA_WIDTH);

    logic [2:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_miso_oe;
    logic                  r_seen_pos;

    logic                  w_abort;
    logic                  w_in_clr;
    logic                  w_in_shift;
    logic                  w_out_load;
    logic                  w_out_shift;
    logic [c_IN_W-1:0]     w_in_par;
    logic                  w_in_msb;
    logic                  w_out_msb;
    logic [DATA_WIDTH-1:0] w_out_par;
    logic                  w_unused;

    assign w_abort = (r_state != c_IDLE) && bus.cs_cond;

    always_comb begin
        w_in_clr    = 1'b0;
        w_in_shift  = 1'b0;
        w_out_load  = 1'b0;
        w_out_shift = 1'b0;
        if (!bus.cs_cond) begin
            case (r_state)
                c_IDLE, c_DECODE:        w_in_clr    = 1'b1;
                c_GET_HDR, c_WRITE_DATA: w_in_shift  = bus.sclk_pos;
                c_READ_LOAD:             w_out_load  = 1'b1;
                // A coincident rising edge takes precedence, so the falling edge is dropped.
                c_READ_SHIFT:            w_out_shift = !bus.sclk_pos && bus.sclk_neg &&
                                                       r_seen_pos && (r_cnt != c_DATA_CNT);
                default: ;
            endcase
        end
    end

    shift_register #(.WIDTH(c_IN_W)) u_in_shift (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clr        (w_in_clr),
        .i_load_en    (1'b0),
        .i_load_data  ('0),
        .i_shift_en   (w_in_shift),
        .i_serial_in  (bus.mosi_cond),
        .o_serial_out (w_in_msb),
        .o_par_out    (w_in_par)
    );

    shift_register #(.WIDTH(DATA_WIDTH)) u_out_shift (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clr        (1'b0),
        .i_load_en    (w_out_load),
        .i_load_data  (bus.mem_rdata),
        .i_shift_en   (w_out_shift),
        .i_serial_in  (1'b0),
        .o_serial_out (w_out_msb),
        .o_par_out    (w_out_par)
    );

    assign w_unused = ^{w_in_msb, w_out_par};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_miso_oe   <= 1'b0;
            r_seen_pos  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_abort) begin
                r_state    <= c_IDLE;
                r_cnt      <= '0;
                r_miso_oe  <= 1'b0;
                r_seen_pos <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (!bus.cs_cond) begin
                            r_state <= c_GET_HDR;
                            r_cnt   <= '0;
                        end
                    end
                    c_GET_HDR: begin
                        if (bus.sclk_pos) begin
                            if (r_cnt == c_HDR_LAST) begin
                                r_state <= c_DECODE;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    c_DECODE: begin
                        r_mem_addr <= w_in_par[c_HDR_BITS-1:1];
                        r_state    <= w_in_par[c_RW_BIT] ? c_READ_LOAD : c_WRITE_DATA;
                        r_cnt      <= '0;
                    end
                    c_WRITE_DATA: begin
                        if (bus.sclk_pos) begin
                            if (r_cnt == c_DATA_LAST) begin
                                // Strobe is registered so it is high for exactly the commit cycle.
                                r_state     <= c_WRITE_COMMIT;
                                r_cnt       <= '0;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= {w_in_par[DATA_WIDTH-2:0], bus.mosi_cond};
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    c_WRITE_COMMIT: begin
                        r_state <= c_DONE;
                        r_cnt   <= '0;
                    end
                    c_READ_LOAD: begin
                        r_state    <= c_READ_SHIFT;
                        r_cnt      <= '0;
                        r_miso_oe  <= 1'b1;
                        r_seen_pos <= 1'b0;
                    end
                    c_READ_SHIFT: begin
                        if (bus.sclk_pos) begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_seen_pos <= 1'b1;
                        end else if (bus.sclk_neg && r_seen_pos && (r_cnt == c_DATA_CNT)) begin
                            r_state    <= c_DONE;
                            r_cnt      <= '0;
                            r_miso_oe  <= 1'b0;
                            r_seen_pos <= 1'b0;
                        end
                    end
                    c_DONE: ;
                    default: begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.miso_oe   = r_miso_oe;
    assign bus.miso      = r_miso_oe & w_out_msb;
    assign bus.busy      = (r_state != c_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_spi_frame_fsm.sv
//------------------------------------------------------------------------------
// Module      : tb_spi_frame_fsm
// Description : Directed scoreboard bench for the SPI frame FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_frame_fsm;
    localparam int AW = 7;
    localparam int DW = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    spi_frame_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spi_frame_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign bus.mem_rdata = mem[bus.mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+DW-1:0] wr_q [$];
    logic             miso_q [$];
    logic [AW+DW-1:0] mon_wr;
    logic             mon_bit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mem_we: got addr %0h data %0h expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_wr = wr_q.pop_front();
                chk("mem_addr", 32'(bus.mem_addr), 32'(mon_wr[AW+DW-1:DW]));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(mon_wr[DW-1:0]));
            end
        end
        if (bus.sclk_pos === 1'b1 && bus.miso_oe === 1'b1) begin
            if (miso_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_miso_bit: got %0b expected no sample", bus.miso);
            end else begin
                mon_bit = miso_q.pop_front();
                chk("miso_bit", 32'(bus.miso), 32'(mon_bit));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sclk_cycle(input logic b, input logic both);
        bus.mosi_cond = b;
        bus.sclk_pos  = 1'b1;
        bus.sclk_neg  = both;
        tick();
        bus.sclk_pos  = 1'b0;
        bus.sclk_neg  = 1'b0;
        tick();
        bus.sclk_neg  = 1'b1;
        tick();
        bus.sclk_neg  = 1'b0;
        tick();
    endtask

    task automatic send_hdr(input logic [AW-1:0] addr, input logic rw);
        bus.cs_cond = 1'b0;
        tick();
        for (int i = AW - 1; i >= 0; i--) sclk_cycle(addr[i], 1'b0);
        sclk_cycle(rw, 1'b0);
    endtask

    task automatic write_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_q.push_back({addr, data});
        send_hdr(addr, 1'b0);
        for (int i = DW - 1; i >= 0; i--) sclk_cycle(data[i], 1'b0);
        chk("busy_after_write", 32'(bus.busy), 32'd1);
    endtask

    task automatic end_frame();
        bus.cs_cond = 1'b1;
        tick();
        chk("busy_after_cs_high", 32'(bus.busy), 32'd0);
    endtask

    task automatic read_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int coinc);
        mem[addr] = data;
        send_hdr(addr, 1'b1);
        chk("miso_oe_on", 32'(bus.miso_oe), 32'd1);
        for (int i = DW - 1; i >= 0; i--) miso_q.push_back(data[i]);
        for (int k = 0; k < DW - 1; k++) sclk_cycle(1'b0, k == coinc);
        bus.sclk_pos = 1'b1;
        tick();
        bus.sclk_pos = 1'b0;
        tick();
        chk("miso_oe_before_last_neg", 32'(bus.miso_oe), 32'd1);
        bus.sclk_neg = 1'b1;
        tick();
        bus.sclk_neg = 1'b0;
        chk("miso_oe_after_last_neg", 32'(bus.miso_oe), 32'd0);
        tick();
        chk("busy_read_done", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        bus.cs_cond   = 1'b1;
        bus.mosi_cond = 1'b0;
        bus.sclk_pos  = 1'b0;
        bus.sclk_neg  = 1'b0;
        repeat (2) tick();

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("rst_miso", 32'(bus.miso), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        reset_n = 1'b1;
        tick();

        // Plain write
        write_frame(7'h2A, 8'hC3);
        repeat (3) tick();
        chk("busy_held_in_done", 32'(bus.busy), 32'd1);
        end_frame();
        chk("mem_addr_hold", 32'(bus.mem_addr), 32'h2A);

        // Plain read
        read_frame(7'h15, 8'h96, -1);
        end_frame();

        // Abort mid write-data, then a clean write
        send_hdr(7'h10, 1'b0);
        for (int i = 0; i < 5; i++) sclk_cycle(1'b1, 1'b0);
        bus.cs_cond = 1'b1;
        tick();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_miso_oe", 32'(bus.miso_oe), 32'd0);
        tick();
        write_frame(7'h01, 8'h55);
        end_frame();

        // Asynchronous reset three bits into a read
        mem[7'h33] = 8'hA5;
        send_hdr(7'h33, 1'b1);
        miso_q.push_back(1'b1);
        miso_q.push_back(1'b0);
        miso_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) sclk_cycle(1'b0, 1'b0);
        chk("pre_reset_miso_oe", 32'(bus.miso_oe), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("async_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        bus.cs_cond = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        read_frame(7'h7F, 8'h3C, -1);
        end_frame();

        // Overrun: extra SCLK cycles after a completed write
        write_frame(7'h40, 8'h81);
        for (int i = 0; i < 4; i++) begin
            sclk_cycle(1'b1, 1'b0);
            chk("overrun_miso_oe", 32'(bus.miso_oe), 32'd0);
        end
        chk("overrun_busy", 32'(bus.busy), 32'd1);
        end_frame();

        // Rising SCLK coincident with CS deassertion during the header
        bus.cs_cond = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) sclk_cycle(1'b1, 1'b0);
        bus.sclk_pos = 1'b1;
        bus.cs_cond  = 1'b1;
        tick();
        bus.sclk_pos = 1'b0;
        chk("coinc_cs_abort", 32'(bus.busy), 32'd0);
        tick();

        // Coincident rising and falling SCLK on the third read bit
        read_frame(7'h15, 8'h96, 2);
        end_frame();

        repeat (4) tick();
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("miso_q_drained", 32'(miso_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
